note_event_merger: RTL and testbench
====================================

Name: note_event_merger

Overview:
- Downstream of the three per-track note monitors.
- Takes each track's single-cycle note events (out_valid / on_off / note) and buffers them in one small FIFO per track.
- Merges them by round-robin into one registered valid/ready event stream for the voice/lane logic.
- Guarantees that no simultaneous events are lost while the buffers have room, and flags and counts any drops.

Parameters:
- DEPTH, 4, entries per track FIFO; power of two, minimum 2.
- AW, 2, log2(DEPTH); FIFO pointer width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wait_  input  1  synchronous flush while high: song paused or reloading.
- in_valid_0 / in_valid_1 / in_valid_2  input  1 each  single-cycle event strobe from track 0/1/2.
- in_on_off_0 / in_on_off_1 / in_on_off_2  input  1 each  1 = note on, 0 = note off.
- in_note_0 / in_note_1 / in_note_2  input  8 each  note number.
- ev_ready  input  1  consumer accepts ev_* this cycle.
- ev_valid  output  1  merged event present.
- ev_track  output  2  source track, 0..2.
- ev_on_off  output  1  event polarity.
- ev_note  output  8  note number.
- overflow  output  3  sticky per-track drop flag.
- drop_count  output  8  total dropped events, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - ev_valid=0, ev_track=0, ev_on_off=0, ev_note=0, overflow=0, drop_count=0.
  - All FIFOs empty; round-robin last-grant pointer = 2, so track 0 has first priority.
- FIFO entry format: {on_off, note[7:0]}, 9 bits. Each FIFO keeps a count 0..DEPTH and wrapping read/write pointers.
- Push: in_valid_k=1 and wait_=0 at an edge writes the entry to FIFO k.
  - If FIFO k is full and is not popped on the same edge, the event is dropped: overflow[k] is set, and drop_count is incremented unless it is already 255.
  - If FIFO k is full but is popped on the same edge, the push is accepted and the count is unchanged.
  - Simultaneous drops on several tracks in one cycle add the number of drops to drop_count, saturating at 255.
- Output register load condition: load = (ev_valid==0) or (ev_ready==1).
- On a load edge:
  - If at least one FIFO is non-empty, select the first non-empty track, searching from (last+1) mod 3 and wrapping.
  - Pop its head into ev_* and set ev_track to that track. Set ev_valid=1 and last = the selected track.
  - If all FIFOs are empty, ev_valid goes to 0 and ev_track/ev_on_off/ev_note hold their values.
- While ev_valid=1 and ev_ready=0, all ev_* outputs hold stable. No FIFO pops.
- Arbitration sees only the FIFO contents before the current edge's pushes, so it never bypasses the FIFO.
- Latency:
  - An event pushed at edge k into an empty system appears on ev_* after edge k+1, provided load holds at edge k+1.
  - Throughput is 1 event per cycle with ev_ready held high.
- Ordering: events from the same track leave in arrival order. Across tracks, order is round-robin only.
- wait_=1 (synchronous, has priority over push and pop):
  - Empties all FIFOs and sets ev_valid=0. Inputs are ignored. last is reset to 2.
  - overflow and drop_count are NOT cleared; they clear only on rst.
- Reset asserted mid-operation discards everything immediately, including any pending output not yet accepted.
- Pointer wrap: read/write pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.

Test Plan:
- Single event: reset; ev_ready=1; pulse in_valid_1 with on_off=1, note=0x3C -> ev_valid=1 one cycle later with ev_track=1, ev_on_off=1, ev_note=0x3C; ev_valid=0 the following cycle.
- Simultaneous events: all three tracks pulse in the same cycle (notes 10/20/30), ev_ready=1 -> three consecutive outputs with ev_track 0,1,2 and notes 10,20,30; overflow=0.
- Backpressure: ev_ready=0; push 4 events on track 0 (notes 1..4) -> ev_valid=1 with note 1 held stable; then ev_ready=1 -> notes 1,2,3,4 on consecutive cycles.
- Overflow: ev_ready=0; push 6 events on track 2 -> overflow=3'b100, drop_count=1. The output holds one event and the FIFO holds 4. With DEPTH=4, a total capacity of 5 with 1 drop is expected.
- Saturation: force 300 drops -> drop_count=255 and overflow stays set. Then pulse wait_ -> ev_valid=0 and FIFOs empty, but drop_count is still 255.
- Fairness and reset: tracks 0 and 1 continuously backlogged with ev_ready=1 -> grants strictly alternate 0,1,0,1. Asserting rst low mid-stream -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/note_event_merger_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : note_event_merger_if                                       |
// | Description : Per-track note event inputs, merged event stream and       |
// |               drop status for the note event merger.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface note_event_merger_if;
  logic       wait_;
  logic       in_valid_0;
  logic       in_valid_1;
  logic       in_valid_2;
  logic       in_on_off_0;
  logic       in_on_off_1;
  logic       in_on_off_2;
  logic [7:0] in_note_0;
  logic [7:0] in_note_1;
  logic [7:0] in_note_2;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_track;
  logic       ev_on_off;
  logic [7:0] ev_note;
  logic [2:0] overflow;
  logic [7:0] drop_count;

  // Merger side: consumes track events and the ready, produces the stream.
  modport slave (
    input  wait_, in_valid_0, in_valid_1, in_valid_2,
    input  in_on_off_0, in_on_off_1, in_on_off_2,
    input  in_note_0, in_note_1, in_note_2, ev_ready,
    output ev_valid, ev_track, ev_on_off, ev_note, overflow, drop_count
  );

  // Environment side: note monitors plus the voice/lane consumer.
  modport master (
    output wait_, in_valid_0, in_valid_1, in_valid_2,
    output in_on_off_0, in_on_off_1, in_on_off_2,
    output in_note_0, in_note_1, in_note_2, ev_ready,
    input  ev_valid, ev_track, ev_on_off, ev_note, overflow, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/note_event_merger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : note_event_merger                                          |
// | Description : Buffers three tracks of note events in per-track FIFOs and |
// |               merges them round-robin into one registered valid/ready    |
// |               stream, flagging and counting dropped events.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module note_event_merger #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  note_event_merger_if.slave  bus
);

  localparam int            NTRK     = 3;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  // FIFO storage and bookkeeping, one set per track
  logic [8:0]    mem_q [NTRK][DEPTH];
  logic [AW-1:0] rd_q  [NTRK];
  logic [AW-1:0] wr_q  [NTRK];
  logic [AW:0]   cnt_q [NTRK];
  logic [AW:0]   cnt_d [NTRK];

  // Output register, arbitration history and drop status
  logic       ev_valid_q;
  logic [1:0] ev_track_q;
  logic       ev_on_off_q;
  logic [7:0] ev_note_q;
  logic [1:0] last_q;
  logic [2:0] overflow_q;
  logic [7:0] drop_count_q;
  logic [7:0] drop_count_d;

  logic [8:0] w_in_data [NTRK];
  logic [2:0] w_in_valid;
  logic [2:0] w_push;
  logic [2:0] w_accept;
  logic [2:0] w_drop;
  logic [2:0] w_pop;
  logic [2:0] w_nonempty;
  logic       w_load;
  logic       w_any;
  logic [1:0] w_sel;
  logic [8:0] w_head;

  function automatic logic [1:0] next_trk(input logic [1:0] t);
    return (t == 2'd2) ? 2'd0 : t + 2'd1;
  endfunction

  // Gather track inputs into indexable form
  always_comb begin
    w_in_valid   = {bus.in_valid_2, bus.in_valid_1, bus.in_valid_0};
    w_in_data[0] = {bus.in_on_off_0, bus.in_note_0};
    w_in_data[1] = {bus.in_on_off_1, bus.in_note_1};
    w_in_data[2] = {bus.in_on_off_2, bus.in_note_2};
  end

  // Round-robin pick among tracks holding data before this edge's pushes
  always_comb begin
    logic [1:0] s0, s1, s2;
    for (int k = 0; k < NTRK; k++) w_nonempty[k] = (cnt_q[k] != '0);
    s0     = next_trk(last_q);
    s1     = next_trk(s0);
    s2     = next_trk(s1);
    w_any  = |w_nonempty;
    w_load = !ev_valid_q || bus.ev_ready;
    if (w_nonempty[s0])      w_sel = s0;
    else if (w_nonempty[s1]) w_sel = s1;
    else                     w_sel = s2;
    case (w_sel)
      2'd0:    w_head = mem_q[0][rd_q[0]];
      2'd1:    w_head = mem_q[1][rd_q[1]];
      default: w_head = mem_q[2][rd_q[2]];
    endcase
  end

  // Per-track push/pop/drop decisions and next occupancy
  always_comb begin
    for (int k = 0; k < NTRK; k++) begin
      w_pop[k]    = !bus.wait_ && w_load && w_any && (w_sel == 2'(k));
      w_push[k]   = !bus.wait_ && w_in_valid[k];
      w_drop[k]   = w_push[k] && (cnt_q[k] == CNT_FULL) && !w_pop[k];
      w_accept[k] = w_push[k] && !w_drop[k];
      cnt_d[k]    = cnt_q[k];
      if (w_accept[k] && !w_pop[k])      cnt_d[k] = cnt_q[k] + 1'b1;
      else if (!w_accept[k] && w_pop[k]) cnt_d[k] = cnt_q[k] - 1'b1;
    end
  end

  // Saturating accumulation of this cycle's drops
  always_comb begin
    logic [1:0] ndrop;
    logic [8:0] sum;
    ndrop = {1'b0, w_drop[0]} + {1'b0, w_drop[1]} + {1'b0, w_drop[2]};
    sum   = {1'b0, drop_count_q} + {7'b0, ndrop};
    drop_count_d = sum[8] ? 8'hFF : sum[7:0];
  end

  // FIFO storage writes; contents need no reset as counts gate every read
  always_ff @(posedge clk) begin
    for (int k = 0; k < NTRK; k++) begin
      if (w_accept[k]) mem_q[k][wr_q[k]] <= w_in_data[k];
    end
  end

  // FIFO pointers and counts; a flush empties every track at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NTRK; k++) begin
        rd_q[k]  <= '0;
        wr_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else if (bus.wait_) begin
      for (int k = 0; k < NTRK; k++) begin
        rd_q[k]  <= '0;
        wr_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTRK; k++) begin
        if (w_accept[k]) wr_q[k] <= wr_q[k] + 1'b1;
        if (w_pop[k])    rd_q[k] <= rd_q[k] + 1'b1;
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Output event register and grant history; payload holds when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid_q  <= 1'b0;
      ev_track_q  <= 2'd0;
      ev_on_off_q <= 1'b0;
      ev_note_q   <= 8'd0;
      last_q      <= 2'd2;
    end else if (bus.wait_) begin
      ev_valid_q  <= 1'b0;
      last_q      <= 2'd2;
    end else if (w_load) begin
      ev_valid_q <= w_any;
      if (w_any) begin
        ev_track_q  <= w_sel;
        ev_on_off_q <= w_head[8];
        ev_note_q   <= w_head[7:0];
        last_q      <= w_sel;
      end
    end
  end

  // Sticky drop flags and count survive a flush; only reset clears them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q   <= 3'b000;
      drop_count_q <= 8'd0;
    end else begin
      overflow_q   <= overflow_q | w_drop;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.ev_valid   = ev_valid_q;
  assign bus.ev_track   = ev_track_q;
  assign bus.ev_on_off  = ev_on_off_q;
  assign bus.ev_note    = ev_note_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_note_event_merger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_note_event_merger                                       |
// | Description : Self-checking bench for note_event_merger using a queue-   |
// |               based reference model plus directed literal expectations.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_note_event_merger;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  note_event_merger_if bus();

  note_event_merger #(.DEPTH(DEPTH), .AW(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per track plus the visible output state
  logic [8:0] mq [3][$];
  int         m_last = 2;
  logic       m_valid = 1'b0;
  logic [1:0] m_track = 2'd0;
  logic       m_oo = 1'b0;
  logic [7:0] m_note = 8'd0;
  logic [2:0] m_ovf = 3'b000;
  int         m_dc = 0;

  // Values the model says the outputs take after the coming edge
  logic       s_valid;
  logic [1:0] s_track;
  logic       s_oo;
  logic [7:0] s_note;
  logic [2:0] s_ovf;
  int         s_dc;

  logic cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every negedge the DUT outputs must equal the model's visible state
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ev_valid",   int'(bus.ev_valid),   int'(m_valid));
      chk("ev_track",   int'(bus.ev_track),   int'(m_track));
      chk("ev_on_off",  int'(bus.ev_on_off),  int'(m_oo));
      chk("ev_note",    int'(bus.ev_note),    int'(m_note));
      chk("overflow",   int'(bus.overflow),   int'(m_ovf));
      chk("drop_count", int'(bus.drop_count), m_dc);
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 3; k++) mq[k].delete();
    m_last = 2; m_valid = 0; m_track = 0; m_oo = 0; m_note = 0; m_ovf = 0; m_dc = 0;
  endtask

  task automatic model_step(input logic [2:0] v, input logic [2:0] oo,
                            input logic [23:0] notes, input logic rdy, input logic wt);
    logic [8:0] d;
    bit found;
    int nd;
    s_valid = m_valid; s_track = m_track; s_oo = m_oo; s_note = m_note;
    s_ovf = m_ovf; s_dc = m_dc;
    if (wt) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
      s_valid = 0;
      m_last  = 2;
      return;
    end
    if (!m_valid || rdy) begin
      found = 0;
      for (int i = 1; i <= 3; i++) begin
        int k;
        k = (m_last + i) % 3;
        if (!found && mq[k].size() > 0) begin
          found = 1;
          d = mq[k].pop_front();
          s_valid = 1; s_track = 2'(k); s_oo = d[8]; s_note = d[7:0];
          m_last = k;
        end
      end
      if (!found) s_valid = 0;
    end
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      if (v[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back({oo[k], notes[8*k +: 8]});
        else begin nd++; s_ovf[k] = 1'b1; end
      end
    end
    s_dc = (m_dc + nd > 255) ? 255 : m_dc + nd;
  endtask

  // One clock of stimulus: drive, predict, take the edge, commit prediction
  task automatic cycle(input logic [2:0] v, input logic [2:0] oo,
                       input logic [23:0] notes, input logic rdy, input logic wt);
    bus.in_valid_0 = v[0]; bus.in_valid_1 = v[1]; bus.in_valid_2 = v[2];
    bus.in_on_off_0 = oo[0]; bus.in_on_off_1 = oo[1]; bus.in_on_off_2 = oo[2];
    bus.in_note_0 = notes[7:0]; bus.in_note_1 = notes[15:8]; bus.in_note_2 = notes[23:16];
    bus.ev_ready = rdy; bus.wait_ = wt;
    model_step(v, oo, notes, rdy, wt);
    @(posedge clk);
    m_valid = s_valid; m_track = s_track; m_oo = s_oo; m_note = s_note;
    m_ovf = s_ovf; m_dc = s_dc;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(3'b000, 3'b000, 24'd0, rdy, 1'b0);
  endtask

  task automatic flush();
    cycle(3'b000, 3'b000, 24'd0, 1'b1, 1'b1);
  endtask

  initial begin
    bus.wait_ = 0; bus.ev_ready = 0;
    bus.in_valid_0 = 0; bus.in_valid_1 = 0; bus.in_valid_2 = 0;
    bus.in_on_off_0 = 0; bus.in_on_off_1 = 0; bus.in_on_off_2 = 0;
    bus.in_note_0 = 0; bus.in_note_1 = 0; bus.in_note_2 = 0;

    // Reset state
    #3;
    chk("rst_ev_valid",   int'(bus.ev_valid), 0);
    chk("rst_ev_note",    int'(bus.ev_note), 0);
    chk("rst_ev_track",   int'(bus.ev_track), 0);
    chk("rst_overflow",   int'(bus.overflow), 0);
    chk("rst_drop_count", int'(bus.drop_count), 0);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Single event on track 1
    cycle(3'b010, 3'b010, {8'd0, 8'h3C, 8'd0}, 1'b1, 1'b0);
    chk("single_early", int'(bus.ev_valid), 0);
    idle(1'b1);
    chk("single_valid", int'(bus.ev_valid), 1);
    chk("single_track", int'(bus.ev_track), 1);
    chk("single_onoff", int'(bus.ev_on_off), 1);
    chk("single_note",  int'(bus.ev_note), 8'h3C);
    idle(1'b1);
    chk("single_gone",  int'(bus.ev_valid), 0);

    // Simultaneous events on all tracks
    flush();
    cycle(3'b111, 3'b000, {8'd30, 8'd20, 8'd10}, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("simul_valid", int'(bus.ev_valid), 1);
      chk("simul_track", int'(bus.ev_track), k);
      chk("simul_note",  int'(bus.ev_note), 10 * (k + 1));
    end
    chk("simul_ovf", int'(bus.overflow), 0);
    idle(1'b1);

    // Backpressure on track 0
    for (int i = 1; i <= 4; i++) cycle(3'b001, 3'b001, {16'd0, 8'(i)}, 1'b0, 1'b0);
    chk("bp_valid", int'(bus.ev_valid), 1);
    chk("bp_note1", int'(bus.ev_note), 1);
    idle(1'b0);
    chk("bp_hold",  int'(bus.ev_note), 1);
    for (int i = 2; i <= 4; i++) begin
      idle(1'b1);
      chk("bp_drain", int'(bus.ev_note), i);
    end
    idle(1'b1);
    chk("bp_empty", int'(bus.ev_valid), 0);

    // Overflow on track 2
    flush();
    for (int i = 1; i <= 6; i++) cycle(3'b100, 3'b100, {8'(i), 16'd0}, 1'b0, 1'b0);
    chk("ovf_flag",  int'(bus.overflow), 3'b100);
    chk("ovf_count", int'(bus.drop_count), 1);
    chk("ovf_head",  int'(bus.ev_note), 1);

    // Saturation of the drop counter, then a flush
    for (int i = 0; i < 300; i++) cycle(3'b111, 3'b000, 24'h050607, 1'b0, 1'b0);
    chk("sat_count", int'(bus.drop_count), 255);
    chk("sat_flag",  int'(bus.overflow), 3'b111);
    flush();
    chk("flush_valid", int'(bus.ev_valid), 0);
    chk("flush_count", int'(bus.drop_count), 255);
    chk("flush_flag",  int'(bus.overflow), 3'b111);
    cycle(3'b010, 3'b000, {8'd0, 8'h55, 8'd0}, 1'b1, 1'b0);
    idle(1'b1);
    chk("post_flush_note",  int'(bus.ev_note), 8'h55);
    chk("post_flush_track", int'(bus.ev_track), 1);
    idle(1'b1);
    chk("post_flush_empty", int'(bus.ev_valid), 0);

    // Fairness with tracks 0 and 1 backlogged
    flush();
    for (int i = 0; i < 10; i++) begin
      cycle(3'b011, 3'b011, {8'd0, 8'(100 + i), 8'(i)}, 1'b1, 1'b0);
      if (i >= 1) chk("fair_track", int'(bus.ev_track), (i - 1) % 2);
    end

    // Asynchronous reset mid-stream
    bus.in_valid_0 = 0; bus.in_valid_1 = 0; bus.in_valid_2 = 0;
    rst = 1'b0;
    #1;
    chk("arst_valid", int'(bus.ev_valid), 0);
    chk("arst_note",  int'(bus.ev_note), 0);
    chk("arst_track", int'(bus.ev_track), 0);
    chk("arst_ovf",   int'(bus.overflow), 0);
    chk("arst_count", int'(bus.drop_count), 0);
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] v;
      logic [2:0] oo;
      logic [23:0] notes;
      logic rdy;
      logic wt;
      v[0]  = ($urandom_range(99) < 45);
      v[1]  = ($urandom_range(99) < 45);
      v[2]  = ($urandom_range(99) < 45);
      oo    = 3'($urandom);
      notes = 24'($urandom);
      rdy   = ($urandom_range(99) < 70);
      wt    = ($urandom_range(99) < 2);
      cycle(v, oo, notes, rdy, wt);
    end

    idle(1'b1);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
